// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: quantises 32-bit filter samples to 16 bits and streams them as mono left-justified serial audio.
// Ports: clk system clock; rst async active-low reset; y_in/y_valid/y_ready sample handshake;
//        bclk/lrclk/sdata serial audio (32 bclk per frame, MSB first);
//        underrun pulses when a frame starts with an empty FIFO; sat_flag pulses when an accepted sample clipped.
// Build option: define I2S_TX_SAT_EN to clamp out-of-range samples instead of wrapping them.
module audio_i2s_tx #(
    parameter int SHIFT    = 15,
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] y_in,
    input  logic        y_valid,
    output logic        y_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun,
    output logic        sat_flag
);
    localparam int CW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] DMAX = CW'(BCLK_DIV - 1);
    localparam logic [32:0] RND = 33'd1 << (SHIFT - 1);
    logic [CW-1:0] cnt, cnt_nx;
    logic [4:0] bitc, bit_nx;
    logic [1:0] occ, occ_nx, wp;
    logic [15:0] f0, f1, hold, word, q;
    logic signed [32:0] sum, q33;
    logic first, tick, fall, fs, push, pop, clip, unused_ok;
    // 33-bit add keeps the rounding carry of full-scale inputs
    assign sum = $signed({y_in[31], y_in}) + $signed(RND);
    assign q33 = sum >>> SHIFT;
    assign unused_ok = ^{sum, q33};
`ifdef I2S_TX_SAT_EN
    logic hi, lo;
    assign hi = !q33[32] && (|q33[31:15]);
    assign lo = q33[32] && !(&q33[31:15]);
    assign clip = hi || lo;
    assign q = hi ? 16'h7fff : lo ? 16'h8000 : q33[15:0];
`else
    assign clip = 1'b0;
    assign q = q33[15:0];
`endif
    always_comb begin
        cnt_nx = (cnt == DMAX) ? '0 : cnt + 1'b1;
        tick = cnt_nx == DMAX;
        fall = tick && bclk;
        // first falling edge after reset opens a frame even though bitc is 0
        fs = fall && (first || bitc == 5'd31);
        pop = fs && occ != 2'd0;
        push = y_valid && y_ready;
        wp = occ - {1'b0, pop};
        occ_nx = occ + {1'b0, push} - {1'b0, pop};
        word = pop ? f0 : hold;
        bit_nx = fs ? 5'd0 : bitc + 5'd1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            bclk <= 1'b0;
            first <= 1'b1;
            bitc <= 5'd0;
            lrclk <= 1'b0;
            sdata <= 1'b0;
            hold <= 16'h0;
            f0 <= 16'h0;
            f1 <= 16'h0;
            occ <= 2'd0;
            y_ready <= 1'b1;
            underrun <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            if (tick) bclk <= ~bclk;
            if (fall) begin
                first <= 1'b0;
                bitc <= bit_nx;
                lrclk <= bit_nx[4];
                sdata <= word[~bit_nx[3:0]];
            end
            if (pop) hold <= f0;
            f0 <= (push && wp == 2'd0) ? q : pop ? f1 : f0;
            f1 <= (push && wp == 2'd1) ? q : f1;
            occ <= occ_nx;
            y_ready <= occ_nx != 2'd2;
            underrun <= fs && occ == 2'd0;
            sat_flag <= push && clip;
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: scoreboard bench for audio_i2s_tx (default SHIFT=15, BCLK_DIV=4).
module tb_audio_i2s_tx;
    localparam int SHIFT = 15;
    localparam int D = 4;
    localparam int F0 = 2 * D - 1;
    logic clk = 1'b0, rst = 1'b0, y_valid = 1'b0;
    logic [31:0] y_in = 32'h0;
    logic y_ready, bclk, lrclk, sdata, underrun, sat_flag;
    int total = 0, bad = 0;
    audio_i2s_tx #(.SHIFT(SHIFT), .BCLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .y_ready(y_ready),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun), .sat_flag(sat_flag)
    );
    always #5 clk = ~clk;
    function automatic logic [16:0] quant(input logic [31:0] y);
        longint v;
        v = (longint'($signed(y)) + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`ifdef I2S_TX_SAT_EN
        if (v > 32767) return {1'b1, 16'h7fff};
        if (v < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, v[15:0]};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask
    logic [15:0] mq[$];
    logic [15:0] cur = 16'h0;
    logic e_ur = 1'b0, e_sat = 1'b0, acc;
    logic [16:0] qq;
    int n = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            cur = 16'h0;
            n = 0;
            e_ur = 1'b0;
            e_sat = 1'b0;
        end else begin
            acc = y_valid && mq.size() < 2;
            n++;
            e_ur = 1'b0;
            if (n >= F0 && (n - F0) % (64 * D) == 0) begin
                if (mq.size() > 0) cur = mq.pop_front();
                else e_ur = 1'b1;
            end
            qq = quant(y_in);
            e_sat = acc && qq[16];
            if (acc) mq.push_back(qq[15:0]);
        end
    end
    always @(negedge clk) begin
        int b;
        b = (n < F0) ? -1 : ((n - F0) / (2 * D)) % 32;
        chk("y_ready", 32'(y_ready), 32'(mq.size() < 2));
        chk("underrun", 32'(underrun), 32'(e_ur));
        chk("sat_flag", 32'(sat_flag), 32'(e_sat));
        chk("bclk", 32'(bclk), 32'(((n + 1) / D) % 2));
        chk("lrclk", 32'(lrclk), 32'(b >= 16));
        chk("sdata", 32'(sdata), 32'(b < 0 ? 1'b0 : cur[15 - (b % 16)]));
    end
    task automatic send(input logic [31:0] v);
        int k;
        y_in = v;
        y_valid = 1'b1;
        k = 0;
        while (!y_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("send_wait", 32'(k < 2000), 32'd1);
        @(negedge clk);
        y_valid = 1'b0;
    endtask
    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(y_ready), 32'd1);
        chk("rst_bclk", 32'(bclk), 32'd0);
        chk("rst_sdata", 32'(sdata), 32'd0);
        rst = 1'b1;
        send(32'h0000_8000);
        send(32'h0000_4000);
        send(32'hffff_c000);
        send(32'h7fff_ffff);
        send(32'hd2d2_8000);
        send(32'h091a_0000);
        repeat (4 * 64 * D) @(negedge clk);
        y_in = 32'h0040_0000;
        y_valid = 1'b1;
        repeat (3 * 64 * D) @(negedge clk);
        y_valid = 1'b0;
        k = 0;
        while (!(n >= F0 && ((n - F0) / (2 * D)) % 32 == 7) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("bit7_wait", 32'(k < 1000), 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("async_bclk", 32'(bclk), 32'd0);
        chk("async_lrclk", 32'(lrclk), 32'd0);
        chk("async_sdata", 32'(sdata), 32'd0);
        chk("async_underrun", 32'(underrun), 32'd0);
        chk("async_sat", 32'(sat_flag), 32'd0);
        chk("async_ready", 32'(y_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2 * 64 * D) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
